// File: rtl/morra_cinese_param.sv
// morra_cinese_param
//  Two-player rock-paper-scissors referee. One manche is judged per clock
//  while in GIOCO; the no-repeat rule forbids the previous winner from
//  replaying the move that won. The match ends on a lead of MARGIN once
//  MIN_MANCHE valid manches are played, or when the round limit MAX is hit.
//
//  Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous reset, active-high
//   INIZIO    in   1      synchronous start/restart; {PRIMO,SECONDO} = config
//   PRIMO     in   2      P1 move: 00 none, 01 sasso, 10 carta, 11 forbice
//   SECONDO   in   2      P2 move, same encoding
//   MANCHE    out  2      round result: 00 none/invalid, 01 P1, 10 P2, 11 draw
//   PARTITA   out  2      match result pulse: 00 none, 01 P1, 10 P2, 11 draw
//   PUNTI1    out  CNT_W  manches won by P1
//   PUNTI2    out  CNT_W  manches won by P2
//   N_MANCHE  out  CNT_W  valid manches played (draws included)
module morra_cinese_param #(
    parameter int MIN_MANCHE = 4,
    parameter int BASE_MAX   = 4,
    parameter int MARGIN     = 2,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INIZIO,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [CNT_W-1:0] PUNTI1,
    output logic [CNT_W-1:0] PUNTI2,
    output logic [CNT_W-1:0] N_MANCHE
);

    // The largest configurable limit must fit, otherwise counters could wrap.
    if (BASE_MAX + 15 >= 2**CNT_W) begin : g_bad_cnt_w
        $error("morra_cinese_param: CNT_W too small for BASE_MAX+15");
    end
    if (MARGIN < 1) begin : g_bad_margin
        $error("morra_cinese_param: MARGIN must be >= 1");
    end

    typedef enum logic {IDLE, GIOCO} state_t;

    localparam logic [CNT_W-1:0]        L_MIN    = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0]        L_BASE   = CNT_W'(BASE_MAX);
    localparam logic [CNT_W:0]          L_MARGIN = (CNT_W+1)'(MARGIN);
    localparam logic signed [CNT_W:0]   L_ONE    = 1;

    state_t                 r_state,   w_state_nxt;
    logic [CNT_W-1:0]       r_max,     w_max_nxt;
    logic [1:0]             r_mossa,   w_mossa_nxt;
    logic [1:0]             r_vinc,    w_vinc_nxt;
    logic signed [CNT_W:0]  r_diff,    w_diff_nxt;
    logic [CNT_W-1:0]       r_punti1,  w_punti1_nxt;
    logic [CNT_W-1:0]       r_punti2,  w_punti2_nxt;
    logic [CNT_W-1:0]       r_n,       w_n_nxt;
    logic [1:0]             r_manche,  w_manche_nxt;
    logic [1:0]             r_partita, w_partita_nxt;

    logic                   w_p1_wins;
    logic                   w_valid;
    logic [1:0]             w_result;
    logic [1:0]             w_win_move;
    logic [CNT_W-1:0]       w_n_inc;
    logic signed [CNT_W:0]  w_diff_post;
    logic [CNT_W:0]         w_diff_abs;
    logic [1:0]             w_lead;

    // Round judgement (independent of state; only used in GIOCO).
    assign w_p1_wins = (PRIMO == 2'b10 && SECONDO == 2'b01) ||
                       (PRIMO == 2'b01 && SECONDO == 2'b11) ||
                       (PRIMO == 2'b11 && SECONDO == 2'b10);

    assign w_result  = (PRIMO == SECONDO) ? 2'b11 :
                       (w_p1_wins         ? 2'b01 : 2'b10);

    // Only the previous winner is restricted; a draw leaves both free.
    assign w_valid   = (PRIMO != 2'b00) && (SECONDO != 2'b00) &&
                       !(r_vinc == 2'b01 && PRIMO   == r_mossa) &&
                       !(r_vinc == 2'b10 && SECONDO == r_mossa);

    assign w_win_move = (w_result == 2'b10) ? SECONDO : PRIMO;

    // Post-update score values, so end checks see this manche's effect.
    assign w_n_inc     = r_n + 1'b1;
    assign w_diff_post = (w_result == 2'b01) ? r_diff + L_ONE :
                         (w_result == 2'b10) ? r_diff - L_ONE : r_diff;
    assign w_diff_abs  = w_diff_post[CNT_W] ? $unsigned(-w_diff_post)
                                            : $unsigned(w_diff_post);
    assign w_lead      = w_diff_post[CNT_W]  ? 2'b10 :
                         (w_diff_post != 0)  ? 2'b01 : 2'b11;

    always_comb begin
        w_state_nxt   = r_state;
        w_max_nxt     = r_max;
        w_mossa_nxt   = r_mossa;
        w_vinc_nxt    = r_vinc;
        w_diff_nxt    = r_diff;
        w_punti1_nxt  = r_punti1;
        w_punti2_nxt  = r_punti2;
        w_n_nxt       = r_n;
        w_manche_nxt  = 2'b00;
        w_partita_nxt = 2'b00;

        if (INIZIO) begin
            // Restart discards any running match without reporting it.
            w_max_nxt    = L_BASE + CNT_W'({PRIMO, SECONDO});
            w_mossa_nxt  = 2'b00;
            w_vinc_nxt   = 2'b00;
            w_diff_nxt   = '0;
            w_punti1_nxt = '0;
            w_punti2_nxt = '0;
            w_n_nxt      = '0;
            w_state_nxt  = GIOCO;
        end else if (r_state == GIOCO && w_valid) begin
            w_manche_nxt = w_result;
            w_n_nxt      = w_n_inc;
            w_diff_nxt   = w_diff_post;
            w_vinc_nxt   = w_result;
            w_mossa_nxt  = w_win_move;
            if (w_result == 2'b01) w_punti1_nxt = r_punti1 + 1'b1;
            if (w_result == 2'b10) w_punti2_nxt = r_punti2 + 1'b1;

            // Margin first; when both fire they agree on the leader.
            if (w_n_inc >= L_MIN && w_diff_abs >= L_MARGIN) begin
                w_partita_nxt = w_lead;
                w_state_nxt   = IDLE;
            end else if (w_n_inc == r_max) begin
                w_partita_nxt = w_lead;
                w_state_nxt   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_max     <= '0;
            r_mossa   <= 2'b00;
            r_vinc    <= 2'b00;
            r_diff    <= '0;
            r_punti1  <= '0;
            r_punti2  <= '0;
            r_n       <= '0;
            r_manche  <= 2'b00;
            r_partita <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_max     <= w_max_nxt;
            r_mossa   <= w_mossa_nxt;
            r_vinc    <= w_vinc_nxt;
            r_diff    <= w_diff_nxt;
            r_punti1  <= w_punti1_nxt;
            r_punti2  <= w_punti2_nxt;
            r_n       <= w_n_nxt;
            r_manche  <= w_manche_nxt;
            r_partita <= w_partita_nxt;
        end
    end

    assign MANCHE   = r_manche;
    assign PARTITA  = r_partita;
    assign PUNTI1   = r_punti1;
    assign PUNTI2   = r_punti2;
    assign N_MANCHE = r_n;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Scoreboard bench for morra_cinese_param: the driver pushes the
// hand-computed expected outputs for each edge; the monitor pops and
// compares shortly after every rising edge.
module tb_morra_cinese_param;

    localparam int CNT_W = 5;
    localparam logic [1:0] N = 2'b00, S = 2'b01, C = 2'b10, F = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             INIZIO;
    logic [1:0]       PRIMO, SECONDO;
    logic [1:0]       MANCHE, PARTITA;
    logic [CNT_W-1:0] PUNTI1, PUNTI2, N_MANCHE;

    morra_cinese_param #(
        .MIN_MANCHE(4), .BASE_MAX(4), .MARGIN(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .INIZIO(INIZIO),
        .PRIMO(PRIMO), .SECONDO(SECONDO),
        .MANCHE(MANCHE), .PARTITA(PARTITA),
        .PUNTI1(PUNTI1), .PUNTI2(PUNTI2), .N_MANCHE(N_MANCHE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic [1:0] p;
        int         n;
        int         a;
        int         b;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string tag, input string fld, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        cmp(e.tag, "MANCHE",   int'(MANCHE),   int'(e.m));
        cmp(e.tag, "PARTITA",  int'(PARTITA),  int'(e.p));
        cmp(e.tag, "N_MANCHE", int'(N_MANCHE), e.n);
        cmp(e.tag, "PUNTI1",   int'(PUNTI1),   e.a);
        cmp(e.tag, "PUNTI2",   int'(PUNTI2),   e.b);
    endtask

    // Drive one edge worth of inputs and queue what the edge must produce.
    task automatic step(input logic ini, input logic [1:0] p1, input logic [1:0] p2,
                        input logic [1:0] em, input logic [1:0] ep,
                        input int en, input int ea, input int eb, input string tag);
        exp_t e;
        @(negedge clk);
        INIZIO  = ini;
        PRIMO   = p1;
        SECONDO = p2;
        e.m = em; e.p = ep; e.n = en; e.a = ea; e.b = eb; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: outputs are registered, so each edge yields one result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z.m = 2'b00; z.p = 2'b00; z.n = 0; z.a = 0; z.b = 0;

        rst = 1'b1; INIZIO = 1'b0; PRIMO = N; SECONDO = N;
        #1;
        z.tag = "reset";
        chk_all(z);
        #14;
        @(negedge clk);
        rst = 1'b0;

        // Moves ignored in IDLE after reset
        step(0, C, S, 2'b00, 2'b00, 0, 0, 0, "idle0");

        // T2 margin win, MAX=4
        step(1, N, N, 2'b00, 2'b00, 0, 0, 0, "t2_start");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t2_m1");
        step(0, S, F, 2'b01, 2'b00, 2, 2, 0, "t2_m2_nomin");
        step(0, F, C, 2'b01, 2'b00, 3, 3, 0, "t2_m3");
        step(0, C, S, 2'b01, 2'b01, 4, 4, 0, "t2_m4_win");
        step(0, C, S, 2'b00, 2'b00, 4, 4, 0, "t2_idle_hold");

        // T3 no-repeat for both players, invalid moves
        step(1, N, N, 2'b00, 2'b00, 0, 0, 0, "t3_start");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t3_m1");
        step(0, C, F, 2'b00, 2'b00, 1, 1, 0, "t3_p1_repeat");
        step(0, N, S, 2'b00, 2'b00, 1, 1, 0, "t3_none");
        step(0, S, C, 2'b10, 2'b00, 2, 1, 1, "t3_p2_win");
        step(0, F, C, 2'b00, 2'b00, 2, 1, 1, "t3_p2_repeat");
        step(0, S, S, 2'b11, 2'b00, 3, 1, 1, "t3_draw");

        // T6 restart after 3 manches, then a fresh margin win through draws
        step(1, N, N, 2'b00, 2'b00, 0, 0, 0, "t6_restart");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t6_m1");
        step(0, S, S, 2'b11, 2'b00, 2, 1, 0, "t6_draw1");
        step(0, S, S, 2'b11, 2'b00, 3, 1, 0, "t6_draw2");
        step(0, F, C, 2'b01, 2'b01, 4, 2, 0, "t6_margin");

        // T4 draw at limit, MAX=4
        step(1, N, N, 2'b00, 2'b00, 0, 0, 0, "t4_start");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t4_m1");
        step(0, S, C, 2'b10, 2'b00, 2, 1, 1, "t4_m2");
        step(0, C, S, 2'b01, 2'b00, 3, 2, 1, "t4_m3");
        step(0, S, C, 2'b10, 2'b11, 4, 2, 2, "t4_m4_draw");

        // T5 limit with lead 1, cfg 0001 -> MAX=5
        step(1, N, S, 2'b00, 2'b00, 0, 0, 0, "t5_start");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t5_m1");
        step(0, S, C, 2'b10, 2'b00, 2, 1, 1, "t5_m2");
        step(0, C, S, 2'b01, 2'b00, 3, 2, 1, "t5_m3");
        step(0, S, C, 2'b10, 2'b00, 4, 2, 2, "t5_m4_nolimit");
        step(0, C, C, 2'b00, 2'b00, 4, 2, 2, "t5_p2_repeat");
        step(0, C, S, 2'b01, 2'b01, 5, 3, 2, "t5_m5_limit");

        // T1 async reset mid-match
        step(1, N, N, 2'b00, 2'b00, 0, 0, 0, "t1_start");
        step(0, C, S, 2'b01, 2'b00, 1, 1, 0, "t1_m1");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        z.tag = "t1_async_rst";
        chk_all(z);
        rst = 1'b0;
        step(0, C, S, 2'b00, 2'b00, 0, 0, 0, "t1_idle");

        repeat (3) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
